// File: rtl/q2_serial_seq.sv
// Bit-serial sequencer: holds ACC/X/F/OP and presents one bit per cycle to an
// external serial ALU stage, shifting the ALU result back into ACC over WIDTH cycles.
module q2_serial_seq #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             cin,
  input  logic             acc_load,
  input  logic [WIDTH-1:0] acc_din,
  input  logic             alu_out,
  input  logic             alu_cout,
  output logic             alu_a0,
  output logic             alu_x0,
  output logic             alu_x1,
  output logic             alu_f,
  output logic             alu_o0,
  output logic             alu_o1,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_acc, r_x;
  logic             r_f;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT);
    done = (r_state == S_DONE);
  end

  // start wins over acc_load in IDLE; DONE performs no register updates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_x   <= '0;
      r_f   <= 1'b0;
      r_op  <= 2'b00;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_x   <= operand;
            r_f   <= cin;
            r_cnt <= '0;
          end else if (acc_load) begin
            r_acc <= acc_din;
          end
        end
        S_SHIFT: begin
          r_acc <= {alu_out, r_acc[WIDTH-1:1]};
          r_x   <= {1'b0, r_x[WIDTH-1:1]};
          r_f   <= alu_cout;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign alu_a0 = r_acc[0];
  assign alu_x0 = r_x[0];
  assign alu_x1 = r_x[1];
  assign alu_f  = r_f;
  assign alu_o0 = r_op[0];
  assign alu_o1 = r_op[1];
  assign acc    = r_acc;
  assign carry  = r_f;

endmodule

// File: tb/tb_q2_serial_seq.sv
// Directed bench for q2_serial_seq with a behavioural full-adder (or pass-through)
// serial ALU closing the loop around the DUT.
module tb_q2_serial_seq;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst, start, cin, acc_load;
  logic [1:0]   op;
  logic [W-1:0] operand, acc_din;
  logic         alu_out, alu_cout;
  logic         alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1;
  logic [W-1:0] acc;
  logic         carry, busy, done;
  logic         stub;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign alu_out  = stub ? alu_x0 : (alu_a0 ^ alu_x0 ^ alu_f);
  assign alu_cout = stub ? 1'b0 :
                    ((alu_a0 & alu_x0) | (alu_a0 & alu_f) | (alu_x0 & alu_f));

  q2_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand), .cin(cin),
    .acc_load(acc_load), .acc_din(acc_din), .alu_out(alu_out), .alu_cout(alu_cout),
    .alu_a0(alu_a0), .alu_x0(alu_x0), .alu_x1(alu_x1), .alu_f(alu_f),
    .alu_o0(alu_o0), .alu_o1(alu_o1), .acc(acc), .carry(carry), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] v);
    acc_load = 1'b1; acc_din = v;
    step();
    acc_load = 1'b0;
    chk("load_acc", 32'(acc), 32'(v));
  endtask

  // Issue start, walk every SHIFT cycle, then check the DONE cycle and the return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] opc, input logic [W-1:0] opnd,
                        input logic c, input logic noisy, input logic ldw,
                        input logic [W-1:0] exp_acc, input logic exp_c);
    int dones = 0;
    start = 1'b1; op = opc; operand = opnd; cin = c;
    acc_load = ldw; acc_din = 12'hEEE;
    step();
    start = 1'b0; acc_load = 1'b0;
    operand = ~opnd; cin = ~c; op = ~opc;
    for (int k = 0; k < W; k++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) dones++;
      chk({tag, "_x0"}, 32'(alu_x0), 32'((opnd >> k) & 1));
      chk({tag, "_x1"}, 32'(alu_x1), 32'((opnd >> (k + 1)) & 1));
      chk({tag, "_op"}, 32'({alu_o1, alu_o0}), 32'(opc));
      if (noisy && k == 3) begin
        start = 1'b1; acc_load = 1'b1; acc_din = 12'hABC; operand = 12'h555;
      end
      if (noisy && k == 4) begin
        start = 1'b0; acc_load = 1'b0;
      end
      step();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_acc"}, 32'(acc), 32'(exp_acc));
    chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
    chk({tag, "_early_done"}, 32'(dones), 32'd0);
    if (noisy) start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_acc_hold"}, 32'(acc), 32'(exp_acc));
    step();
    chk({tag, "_still_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; operand = '0; cin = 1'b0;
    acc_load = 1'b0; acc_din = '0; stub = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op", 32'({alu_o1, alu_o0}), 32'd0);

    // basic add
    load(12'h123);
    run_op("add", 2'b01, 12'h0FF, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0);

    // wraparound carry-out, then carry-in only
    load(12'hFFF);
    run_op("wrap", 2'b00, 12'h001, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    load(12'h000);
    run_op("cin", 2'b11, 12'h000, 1'b1, 1'b0, 1'b0, 12'h001, 1'b0);

    // pass-through ALU: ACC becomes operand
    stub = 1'b1;
    load(12'h3C3);
    run_op("pass", 2'b10, 12'hA5C, 1'b0, 1'b0, 1'b0, 12'hA5C, 1'b0);
    stub = 1'b0;

    // start/acc_load noise during SHIFT and DONE
    load(12'h123);
    run_op("noisy", 2'b01, 12'h0FF, 1'b0, 1'b1, 1'b0, 12'h222, 1'b0);

    // reset in the 5th SHIFT cycle aborts with no done pulse
    load(12'h123);
    start = 1'b1; operand = 12'h0FF; cin = 1'b0; op = 2'b01;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_acc", 32'(acc), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    begin
      int dn = 0;
      for (int k = 0; k < 14; k++) begin
        if (done || busy) dn++;
        step();
      end
      chk("abort_no_done", 32'(dn), 32'd0);
    end
    load(12'h123);
    run_op("after_rst", 2'b01, 12'h0FF, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0);

    // start and acc_load together: old ACC is used
    load(12'h100);
    run_op("start_ld", 2'b01, 12'h011, 1'b0, 1'b0, 1'b1, 12'h111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
